// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
//
// Turns ASCII characters offered over a valid/ready handshake into a Morse
// keyed on/off level with exact unit timing. key_out drives the LED directly.
//
// Parameters
//   UNIT_CYCLES  clock cycles per Morse unit (>= 2)
//
// Ports
//   CLK         in   system clock, single domain
//   RST         in   synchronous, active-high reset
//   char_valid  in   char_data holds a character offered for transmission
//   char_data   in   8-bit ASCII character
//   char_ready  out  a character can be accepted this cycle
//   key_out     out  1 = mark (LED on), 0 = space
//   busy        out  a character or its trailing gap is in progress
//   err         out  one-cycle pulse: the accepted character is unsupported
//
// Build option
//   MORSE_KEYER_PUNCT_EN  widens code storage to 6 symbols and adds
//                         '.', ',', '?', '/', '='. Without it those
//                         characters are unsupported.
//
// Timing (u = UNIT_CYCLES): dot 1u mark, dash 3u mark, 1u between symbols,
// 3u after each letter/digit, 4u for ' '. The last cycle of a trailing gap
// is spent in IDLE with char_ready high, so a character held valid
// back-to-back starts its first mark with the gap still exactly 3u/4u long.
// -----------------------------------------------------------------------------
module morse_keyer #(
    parameter int UNIT_CYCLES = 1600000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err
);

`ifdef MORSE_KEYER_PUNCT_EN
    localparam int SYM_W = 6;
`else
    localparam int SYM_W = 5;
`endif
    localparam int IDX_W = 3;
    localparam int CNT_W = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(UNIT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SYMGAP,
        CHARGAP,
        WORDGAP,
        ERR
    } state_t;

    // One Morse code: symbols right-aligned, bit (len-1) sent first, 1 = dash.
    // len == 0 with ok set is the word space.
    typedef struct packed {
        logic             ok;
        logic [2:0]       len;
        logic [SYM_W-1:0] sym;
    } code_t;

    function automatic code_t mk(input logic [2:0] len, input logic [5:0] bits);
        code_t r;
        r.ok  = 1'b1;
        r.len = len;
        r.sym = SYM_W'(bits);
        return r;
    endfunction

    function automatic code_t encode(input logic [7:0] c);
        logic [7:0] u;
        code_t      r;
        r = '0;
        u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
        case (u)
            "A": r = mk(3'd2, 6'b000001);
            "B": r = mk(3'd4, 6'b001000);
            "C": r = mk(3'd4, 6'b001010);
            "D": r = mk(3'd3, 6'b000100);
            "E": r = mk(3'd1, 6'b000000);
            "F": r = mk(3'd4, 6'b000010);
            "G": r = mk(3'd3, 6'b000110);
            "H": r = mk(3'd4, 6'b000000);
            "I": r = mk(3'd2, 6'b000000);
            "J": r = mk(3'd4, 6'b000111);
            "K": r = mk(3'd3, 6'b000101);
            "L": r = mk(3'd4, 6'b000100);
            "M": r = mk(3'd2, 6'b000011);
            "N": r = mk(3'd2, 6'b000010);
            "O": r = mk(3'd3, 6'b000111);
            "P": r = mk(3'd4, 6'b000110);
            "Q": r = mk(3'd4, 6'b001101);
            "R": r = mk(3'd3, 6'b000010);
            "S": r = mk(3'd3, 6'b000000);
            "T": r = mk(3'd1, 6'b000001);
            "U": r = mk(3'd3, 6'b000001);
            "V": r = mk(3'd4, 6'b000001);
            "W": r = mk(3'd3, 6'b000011);
            "X": r = mk(3'd4, 6'b001001);
            "Y": r = mk(3'd4, 6'b001011);
            "Z": r = mk(3'd4, 6'b001100);
            "0": r = mk(3'd5, 6'b011111);
            "1": r = mk(3'd5, 6'b001111);
            "2": r = mk(3'd5, 6'b000111);
            "3": r = mk(3'd5, 6'b000011);
            "4": r = mk(3'd5, 6'b000001);
            "5": r = mk(3'd5, 6'b000000);
            "6": r = mk(3'd5, 6'b010000);
            "7": r = mk(3'd5, 6'b011000);
            "8": r = mk(3'd5, 6'b011100);
            "9": r = mk(3'd5, 6'b011110);
`ifdef MORSE_KEYER_PUNCT_EN
            ".": r = mk(3'd6, 6'b010101);
            ",": r = mk(3'd6, 6'b110011);
            "?": r = mk(3'd6, 6'b001100);
            "/": r = mk(3'd5, 6'b010010);
            "=": r = mk(3'd5, 6'b010001);
`endif
            " ": r = mk(3'd0, 6'b000000);
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       units;
    logic [SYM_W-1:0] code_sym;
    logic [IDX_W-1:0] sym_idx;
    logic             ready_en;

    code_t            in_code;
    logic             accept;
    logic             unit_end;
    logic             cur_dash;
    logic [1:0]       mark_last;
    logic             load_code;
    logic             next_sym;

    assign in_code   = encode(char_data);
    assign char_ready = ready_en && (state == IDLE);
    assign accept    = char_valid && char_ready;
    assign unit_end  = (cnt == CNT_LAST);
    assign cur_dash  = code_sym[sym_idx];
    assign mark_last = cur_dash ? 2'd2 : 2'd0;

    assign key_out = (state == MARK);
    assign busy    = (state != IDLE);
    assign err     = (state == ERR);

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load_code  = 1'b0;
        next_sym   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!in_code.ok) begin
                        state_next = ERR;
                    end else if (in_code.len == 3'd0) begin
                        state_next = WORDGAP;
                    end else begin
                        state_next = MARK;
                        load_code  = 1'b1;
                    end
                end
            end
            MARK: begin
                if (unit_end && units == mark_last) begin
                    state_next = (sym_idx == '0) ? CHARGAP : SYMGAP;
                end
            end
            SYMGAP: begin
                if (unit_end) begin
                    state_next = MARK;
                    next_sym   = 1'b1;
                end
            end
            // Trailing gaps end one cycle early; that cycle is the IDLE cycle.
            CHARGAP: begin
                if (cnt == CNT_PENULT && units == 2'd2) state_next = IDLE;
            end
            WORDGAP: begin
                if (cnt == CNT_PENULT && units == 2'd3) state_next = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            units    <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
            if (state_next != state || state == IDLE) begin
                cnt   <= '0;
                units <= '0;
            end else if (unit_end) begin
                cnt   <= '0;
                units <= units + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: the code registers are pure datapath, always loaded before use, so
    // they carry no reset.
    always_ff @(posedge CLK) begin
        if (load_code) begin
            code_sym <= in_code.sym;
            sym_idx  <= in_code.len - 3'd1;
        end else if (next_sym) begin
            sym_idx <= sym_idx - 3'd1;
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
module tb_morse_keyer;

    localparam int U = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready, key_out, busy, err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit key;
        bit ready;
        bit busy;
        bit err;
    } exp_t;

    exp_t exp_q[$];

    morse_keyer #(.UNIT_CYCLES(U)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    // Reference table as dot/dash text; "" is the word space, "X" unsupported.
    function automatic string morse_of(input logic [7:0] c);
        case (c)
            "A", "a": return ".-";    "B", "b": return "-...";
            "C", "c": return "-.-.";  "D", "d": return "-..";
            "E", "e": return ".";     "F", "f": return "..-.";
            "G", "g": return "--.";   "H", "h": return "....";
            "I", "i": return "..";    "J", "j": return ".---";
            "K", "k": return "-.-";   "L", "l": return ".-..";
            "M", "m": return "--";    "N", "n": return "-.";
            "O", "o": return "---";   "P", "p": return ".--.";
            "Q", "q": return "--.-";  "R", "r": return ".-.";
            "S", "s": return "...";   "T", "t": return "-";
            "U", "u": return "..-";   "V", "v": return "...-";
            "W", "w": return ".--";   "X", "x": return "-..-";
            "Y", "y": return "-.--";  "Z", "z": return "--..";
            "0": return "-----";  "1": return ".----";  "2": return "..---";
            "3": return "...--";  "4": return "....-";  "5": return ".....";
            "6": return "-....";  "7": return "--...";  "8": return "---..";
            "9": return "----.";
`ifdef MORSE_KEYER_PUNCT_EN
            ".": return ".-.-.-"; ",": return "--..--"; "?": return "..--..";
            "/": return "-..-.";  "=": return "-...-";
`endif
            " ": return "";
            default: return "X";
        endcase
    endfunction

    function automatic void push(bit k, bit r, bit b, bit e);
        exp_t t;
        t.key = k; t.ready = r; t.busy = b; t.err = e;
        exp_q.push_back(t);
    endfunction

    // Expected per-cycle outputs after each accept; the final entry of each
    // character is the ready cycle in which the next character is taken.
    function automatic void append_char(input logic [7:0] c);
        string s;
        s = morse_of(c);
        if (s == "X") begin
            push(0, 0, 1, 1);
        end else if (s.len() == 0) begin
            repeat (4 * U - 1) push(0, 0, 1, 0);
        end else begin
            for (int i = 0; i < s.len(); i++) begin
                repeat ((s.getc(i) == "-") ? 3 * U : U) push(1, 0, 1, 0);
                if (i < s.len() - 1) repeat (U) push(0, 0, 1, 0);
            end
            repeat (3 * U - 1) push(0, 0, 1, 0);
        end
        push(0, 1, 0, 0);
    endfunction

    // Sends s back-to-back; with noise, char_valid/char_data are scrambled
    // whenever the block is not expected to be ready.
    task automatic run_sequence(input string name, input string s, input bit noise);
        exp_t e;
        int   ci;
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) append_char(s.getc(i));
        checks++;
        if (char_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s start: char_ready=%b required 1", name, char_ready);
        end
        char_valid = 1'b1;
        char_data  = s.getc(0);
        ci = 1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge CLK); #1;
            e = exp_q[i];
            checks++;
            if ({key_out, char_ready, busy, err} !== {e.key, e.ready, e.busy, e.err}) begin
                errors++;
                $display("FAIL %s cycle %0d: key/ready/busy/err=%b%b%b%b required %b%b%b%b",
                         name, i, key_out, char_ready, busy, err,
                         e.key, e.ready, e.busy, e.err);
            end
            if (e.ready) begin
                if (ci < s.len()) begin
                    char_valid = 1'b1;
                    char_data  = s.getc(ci);
                    ci++;
                end else begin
                    char_valid = 1'b0;
                    char_data  = 8'($urandom);
                end
            end else if (noise) begin
                char_valid = 1'($urandom_range(0, 1));
                char_data  = 8'($urandom);
            end
        end
        char_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            checks++;
            if ({key_out, char_ready, busy, err} !== 4'b0000) begin
                errors++;
                $display("FAIL reset: key/ready/busy/err=%b%b%b%b required 0000",
                         key_out, char_ready, busy, err);
            end
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if ({key_out, char_ready, busy, err} !== 4'b0100) begin
            errors++;
            $display("FAIL reset release: key/ready/busy/err=%b%b%b%b required 0100",
                     key_out, char_ready, busy, err);
        end
    endtask

    task automatic test_single_e();
        run_sequence("single_E", "E", 1'b0);
    endtask

    task automatic test_back_to_back();
        run_sequence("a_then_T", "aT", 1'b0);
    endtask

    task automatic test_word_gap();
        run_sequence("E_space_E", "E E", 1'b0);
    endtask

    task automatic test_unsupported();
        run_sequence("hash", "#", 1'b0);
    endtask

    task automatic test_punct();
        run_sequence("question", "?", 1'b0);
    endtask

    task automatic test_reset_mid_char();
        char_valid = 1'b1;
        char_data  = "0";
        @(posedge CLK); #1;
        char_valid = 1'b0;
        // Cycle 1 is the first mark cycle; dash 2 covers cycles 17..28.
        repeat (21) begin
            @(posedge CLK); #1;
        end
        checks++;
        if (key_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_dash key_out=%b required 1", key_out);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks++;
        if ({key_out, char_ready, busy, err} !== 4'b0000) begin
            errors++;
            $display("FAIL abort: key/ready/busy/err=%b%b%b%b required 0000",
                     key_out, char_ready, busy, err);
        end
        repeat (6) begin
            @(posedge CLK); #1;
            checks++;
            if ({key_out, char_ready, busy, err} !== 4'b0100) begin
                errors++;
                $display("FAIL after_abort: key/ready/busy/err=%b%b%b%b required 0100",
                         key_out, char_ready, busy, err);
            end
        end
    endtask

    task automatic test_random();
        string pool = "AZaz09kQ5 #@~?.,/=";
        for (int n = 0; n < 15; n++) begin
            string s = "";
            int    len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                string t = " ";
                t.putc(0, pool.getc($urandom_range(0, pool.len() - 1)));
                s = {s, t};
            end
            run_sequence($sformatf("random_%0d", n), s, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK); #1;
                checks++;
                if ({key_out, char_ready, busy, err} !== 4'b0100) begin
                    errors++;
                    $display("FAIL random_idle: key/ready/busy/err=%b%b%b%b required 0100",
                             key_out, char_ready, busy, err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_e();
        test_back_to_back();
        test_word_gap();
        test_unsupported();
        test_reset_mid_char();
        test_punct();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
